// File: rtl/fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface fetch_if;
  // Handshake: the master holds imem_req=1 with a constant imem_addr until the
  // slave answers with imem_valid=1 (same cycle or later); imem_rdata is only
  // meaningful while imem_valid=1, and the transfer completes on that clock edge.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, keeps one
// instruction-memory request outstanding and inserts NOP bubbles on stalls/redirects.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        if_id_enable,
  input  logic        mux_sel_IF,
  input  logic [31:0] pc_branch_value,
  input  logic        IF_flush,
  fetch_if.master     imem,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] req_addr;
  logic [31:0] buf_q;

  logic        redirect;
  logic        advance;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = pc_enable & (mux_sel_IF | IF_flush);
  assign advance  = pc_enable & if_id_enable & ~redirect;
  assign target   = mux_sel_IF ? (pc_branch_value & ~32'h3) : pc_inc;

  // DROP keeps the stale address on the bus until its response is swallowed.
  assign imem.imem_req  = (state != S_HOLD);
  assign imem.imem_addr = req_addr;
  assign dbg_state      = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      pc_q        <= RESET_PC;
      req_addr    <= RESET_PC;
      buf_q       <= '0;
      instruction <= NOP;
      pc          <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem.imem_valid) begin
            if (redirect) begin
              pc_q        <= target;
              req_addr    <= target;
              instruction <= NOP;
              pc          <= '0;
            end else if (advance) begin
              instruction <= imem.imem_rdata;
              pc          <= pc_q;
              pc_q        <= pc_inc;
              req_addr    <= pc_inc;
            end else begin
              buf_q <= imem.imem_rdata;
              state <= S_HOLD;
            end
          end else if (redirect) begin
            pc_q        <= target;
            instruction <= NOP;
            pc          <= '0;
            state       <= S_DROP;
          end else if (if_id_enable) begin
            instruction <= NOP;
            pc          <= '0;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc_q        <= target;
            req_addr    <= target;
            instruction <= NOP;
            pc          <= '0;
            state       <= S_REQ;
          end else if (advance) begin
            instruction <= buf_q;
            pc          <= pc_q;
            pc_q        <= pc_inc;
            req_addr    <= pc_inc;
            state       <= S_REQ;
          end
        end

        S_DROP: begin
          if (redirect) pc_q <= target;
          // Re-issue at the newest PC, including one redirected in this same cycle.
          if (imem.imem_valid) begin
            req_addr <= redirect ? target : pc_q;
            state    <= S_REQ;
          end
          if (if_id_enable || redirect) begin
            instruction <= NOP;
            pc          <= '0;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: random-latency memory, random stalls/redirects, and a
// scoreboard of the expected instruction stream checked by a negedge monitor.
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] BUBBLE   = {NOP, 32'h0};

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        pc_enable = 1'b1;
  logic        if_id_enable = 1'b1;
  logic        mux_sel_IF = 1'b0;
  logic [31:0] pc_branch_value = 32'h0;
  logic        IF_flush = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [1:0]  dbg_state;

  fetch_if bus ();

  fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_enable       (pc_enable),
    .if_id_enable    (if_id_enable),
    .mux_sel_IF      (mux_sel_IF),
    .pc_branch_value (pc_branch_value),
    .IF_flush        (IF_flush),
    .imem            (bus.master),
    .instruction     (instruction),
    .pc              (pc),
    .dbg_state       (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int deliveries = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [30:0] h;
    h = (a[30:0] * 31'h2545_F491) ^ {a[31], 30'h1234_5678};
    return {1'b1, h};
  endfunction

  // ---------------- instruction memory model ----------------
  int          max_lat = 0;
  int          mem_cnt = 0;
  logic        outstanding = 1'b0;
  logic [31:0] out_addr = 32'h0;

  assign bus.imem_valid = bus.imem_req && (mem_cnt == 0);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always @(posedge clock) begin
    if (!reset) begin
      mem_cnt     <= $urandom_range(0, max_lat);
      outstanding <= 1'b0;
    end else if (bus.imem_req && bus.imem_valid) begin
      mem_cnt     <= $urandom_range(0, max_lat);
      outstanding <= 1'b0;
    end else if (bus.imem_req) begin
      if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (!outstanding) out_addr <= bus.imem_addr;
      outstanding <= 1'b1;
    end
  end

  // ---------------- reference model: expected fetch stream ----------------
  // The stage always delivers consecutive PCs; an accepted redirect restarts
  // the stream at the branch target (or one past the pending PC on a flush).
  logic [63:0] exp_q[$];
  logic        redir_flag = 1'b0;
  logic        hold_flag  = 1'b0;

  function automatic void push_run(input logic [31:0] start);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({mem_word(a), a});
      a = a + 32'd4;
    end
  endfunction

  always @(posedge clock) begin
    logic [31:0] nxt;
    logic [63:0] last;
    if (!reset) begin
      exp_q.delete();
      push_run(RESET_PC);
      redir_flag = 1'b0;
      hold_flag  = 1'b0;
    end else begin
      redir_flag = pc_enable && (mux_sel_IF || IF_flush);
      hold_flag  = !if_id_enable && !redir_flag;
      if (redir_flag) begin
        nxt = mux_sel_IF ? {pc_branch_value[31:2], 2'b00} : exp_q[0][31:0] + 32'd4;
        exp_q.delete();
        push_run(nxt);
      end
      if (exp_q.size() < 8) begin
        last = exp_q[exp_q.size()-1];
        push_run(last[31:0] + 32'd4);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [63:0] prev = BUBBLE;

  always @(negedge clock) begin
    logic [63:0] cur;
    logic [63:0] exp;
    if (!reset) begin
      prev = BUBBLE;
    end else begin
      cur = {instruction, pc};
      if (redir_flag) check("redirect_nop", cur, BUBBLE);
      else if (hold_flag) check("ifid_hold", cur, prev);
      if (outstanding)
        check("addr_stable", {31'h0, bus.imem_req, bus.imem_addr}, {31'h0, 1'b1, out_addr});
      if (cur != prev && cur != BUBBLE) begin
        exp = exp_q.pop_front();
        check("delivery", cur, exp);
        deliveries++;
      end
      prev = cur;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ctl(input logic pe, input logic ie, input logic ms,
                         input logic fl, input logic [31:0] br);
    pc_enable       = pe;
    if_id_enable    = ie;
    mux_sel_IF      = ms;
    IF_flush        = fl;
    pc_branch_value = br;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      2:       return 32'h0000_0080;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int   rand_start;
    logic found;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_ifid", {instruction, pc}, BUBBLE);
    check("reset_req", {31'h0, bus.imem_req, bus.imem_addr}, {31'h0, 1'b1, RESET_PC});
    @(negedge clock);
    reset = 1'b1;

    // same-cycle memory, sequential stream
    step();
    check("first_fetch", {instruction, pc}, {mem_word(32'h0), 32'h0});
    step();
    check("second_fetch", {instruction, pc}, {mem_word(32'h4), 32'h4});

    // stall while word@8 returns
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("hold_state", {30'h0, dbg_state}, 32'd1);
    check("hold_noreq", {31'h0, bus.imem_req}, 32'd0);
    step();
    step();
    check("hold_ifid", {instruction, pc}, {mem_word(32'h4), 32'h4});
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("hold_release", {instruction, pc}, {mem_word(32'h8), 32'h8});
    check("hold_next_addr", {32'h0, bus.imem_addr}, 64'hC);

    // redirect to 0x40 with same-cycle response for C
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    step();
    check("redir_bubble", {instruction, pc}, BUBBLE);
    check("redir_addr", {32'h0, bus.imem_addr}, 64'h40);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("redir_target", {instruction, pc}, {mem_word(32'h40), 32'h40});

    // wrap at the top of the address space
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step();
    check("wrap_addr_hi", {32'h0, bus.imem_addr}, 64'hFFFF_FFFC);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("wrap_top", {instruction, pc}, {mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    check("wrap_addr_zero", {32'h0, bus.imem_addr}, 64'h0);
    step();

    // pc_enable=0 masks a redirect
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
    step();
    check("pcen_hold", {instruction, pc}, {mem_word(32'h0), 32'h0});
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("pcen_sequential", {instruction, pc}, {mem_word(32'h4), 32'h4});

    // randomized traffic with multi-cycle memory
    max_lat    = 3;
    rand_start = deliveries;
    for (int i = 0; i < 1500; i++) begin
      set_ctl($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, rand_target());
      step();
    end
    n_checks++;
    if (deliveries - rand_start < 100) begin
      n_errors++;
      $display("FAIL liveness: got %0d deliveries expected at least 100", deliveries - rand_start);
    end

    // reset asserted while a request is outstanding
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (bus.imem_req && !bus.imem_valid) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL wait_outstanding: got none expected an outstanding request within 50 cycles");
    end
    #2;
    max_lat = 0;
    reset   = 1'b0;
    #1;
    check("midreset_ifid", {instruction, pc}, BUBBLE);
    check("midreset_req", {31'h0, bus.imem_req, bus.imem_addr}, {31'h0, 1'b1, RESET_PC});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("post_reset_fetch", {instruction, pc}, {mem_word(RESET_PC), RESET_PC});
    step();
    check("post_reset_next", {instruction, pc}, {mem_word(RESET_PC + 32'd4), RESET_PC + 32'd4});
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
